// File: rtl/pool_nl_accum.sv
// pool_nl_accum
// Post-adder-tree stage of the pool/nonlinearity unit. A valid bit travels
// alongside each sample through a delay line matched to the adder tree.
// Tree outputs are accumulated over several input-channel passes, with the
// bias added on the first pass. The result is saturated to WID bits, sent
// through the nonlinearity and max-pooled over a window of 1, 2 or 4 values.
// Pooled results are queued in a small output FIFO with valid/ready handshake.
//
// Build option:
//   POOL_NL_RELU_EN - when defined, negative values are clamped to zero
//                     before pooling. Otherwise the nonlinearity is identity.
//
// Ports:
//   clk, rst      - clock; asynchronous active-high reset
//   clear         - synchronous layer restart; also loads cfg_n_pass/cfg_pool
//   adder_enable  - adder tree enable; advances the valid delay line
//   sample_valid  - tree inputs this cycle carry a real sample
//   tree_sum      - signed adder tree output
//   bias          - signed bias, taken on the first pass of each output value
//   cfg_n_pass    - passes per output value (0 behaves as 1)
//   cfg_pool      - pool window select: 0->1, 1->2, 2/3->4
//   out_data      - FIFO head (0 while the FIFO is empty)
//   out_valid     - FIFO not empty
//   out_ready     - consumer takes the head this cycle
//   stall         - upstream must stop issuing samples
//   err_overflow  - sticky: a result was dropped because the FIFO was full

`ifndef WID_PE_BITS
`define WID_PE_BITS 16
`endif

module pool_nl_accum #(
   parameter int WID        = `WID_PE_BITS,
   parameter int ACC_GUARD  = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int TREE_LAT   = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  adder_enable,
   input  logic                  sample_valid,
   input  logic signed [WID-1:0] tree_sum,
   input  logic signed [WID-1:0] bias,
   input  logic [3:0]            cfg_n_pass,
   input  logic [1:0]            cfg_pool,
   output logic signed [WID-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  stall,
   output logic                  err_overflow
);

   localparam int AW = WID + ACC_GUARD;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic signed [AW-1:0] SAT_MAX = {{(ACC_GUARD + 1){1'b0}}, {(WID - 1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(ACC_GUARD + 1){1'b1}}, {(WID - 1){1'b0}}};
   localparam logic [CW-1:0] STALL_LEVEL = CW'(FIFO_DEPTH - TREE_LAT);
   localparam logic [CW-1:0] FULL_LEVEL  = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_SLOT   = PW'(FIFO_DEPTH - 1);

   logic [TREE_LAT-1:0]   vld;
   logic [3:0]            n_pass_r;
   logic [1:0]            pool_r;
   logic [3:0]            pass_cnt;
   logic [1:0]            pool_cnt;
   logic signed [AW-1:0]  acc;
   logic signed [WID-1:0] pmax;

   logic signed [WID-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         count;

   logic                  x_valid;
   logic [3:0]            pass_last_idx;
   logic [1:0]            pool_last_idx;
   logic                  pass_last;
   logic                  pool_last;
   logic signed [AW-1:0]  acc_base;
   logic signed [AW-1:0]  acc_sum;
   logic signed [WID-1:0] sat_val;
   logic signed [WID-1:0] nl_val;
   logic signed [WID-1:0] pool_val;
   logic                  push;
   logic                  pop;
   logic                  do_write;

   // The valid bit follows the sample through the tree, moving only on the
   // cycles the tree itself moves so that a paused tree cannot create or
   // lose samples. clear discards everything still in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
      end else if (clear) begin
         vld <= '0;
      end else if (adder_enable) begin
         vld <= {vld[TREE_LAT-2:0], sample_valid};
      end
   end

   // Layer configuration is captured only on clear so a mid-layer change on
   // the cfg pins cannot split an output value across two settings.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_pass_r <= '0;
         pool_r   <= '0;
      end else if (clear) begin
         n_pass_r <= cfg_n_pass;
         pool_r   <= cfg_pool;
      end
   end

   // Datapath from tree output to the value offered to the FIFO. A sample is
   // consumed only on an enabled cycle, since the tree output is held while
   // the tree is paused. The accumulator wraps freely in its guard bits and
   // saturation is applied once, on the final pass.
   always_comb begin
      x_valid       = adder_enable && vld[TREE_LAT-1] && !clear;
      pass_last_idx = (n_pass_r == 4'd0) ? 4'd0 : n_pass_r - 4'd1;
      pool_last_idx = (pool_r == 2'd0) ? 2'd0 : ((pool_r == 2'd1) ? 2'd1 : 2'd3);
      pass_last     = (pass_cnt == pass_last_idx);
      pool_last     = (pool_cnt == pool_last_idx);
      acc_base      = (pass_cnt == 4'd0) ? {{ACC_GUARD{bias[WID-1]}}, bias} : acc;
      acc_sum       = acc_base + {{ACC_GUARD{tree_sum[WID-1]}}, tree_sum};
      if (acc_sum > SAT_MAX) begin
         sat_val = SAT_MAX[WID-1:0];
      end else if (acc_sum < SAT_MIN) begin
         sat_val = SAT_MIN[WID-1:0];
      end else begin
         sat_val = acc_sum[WID-1:0];
      end
`ifdef POOL_NL_RELU_EN
      nl_val = sat_val[WID-1] ? '0 : sat_val;
`else
      nl_val = sat_val;
`endif
      pool_val = ((pool_cnt == 2'd0) || (nl_val > pmax)) ? nl_val : pmax;
      push     = x_valid && pass_last && pool_last;
      pop      = out_valid && out_ready;
      do_write = push && ((count != FULL_LEVEL) || pop);
   end

   // Pass and pool counters plus the running accumulator and pool maximum.
   // The pooled value is written to the FIFO on the same edge the window
   // closes, which keeps in-flight work bounded by the tree depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         pass_cnt <= '0;
         pool_cnt <= '0;
         pmax     <= '0;
      end else if (clear) begin
         acc      <= '0;
         pass_cnt <= '0;
         pool_cnt <= '0;
         pmax     <= '0;
      end else if (x_valid) begin
         acc      <= acc_sum;
         pass_cnt <= pass_last ? 4'd0 : pass_cnt + 4'd1;
         if (pass_last) begin
            pmax     <= pool_val;
            pool_cnt <= pool_last ? 2'd0 : pool_cnt + 2'd1;
         end
      end
   end

   // Output FIFO. When full, a push is accepted only if the head leaves on
   // the same edge; otherwise the value is dropped and the error latches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         err_overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         err_overflow <= 1'b0;
      end else begin
         if (push && !do_write) begin
            err_overflow <= 1'b1;
         end
         if (do_write) begin
            mem[wr_ptr] <= pool_val;
            wr_ptr      <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PW'(1);
         end
         case ({do_write, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Stall leaves room for every sample that can already be inside the tree
   // when upstream reacts, so an obeying producer never overflows the FIFO.
   always_comb begin
      out_valid = (count != '0);
      out_data  = out_valid ? mem[rd_ptr] : '0;
      stall     = (count >= STALL_LEVEL);
   end

endmodule

// File: tb/tb_pool_nl_accum.sv
// tb_pool_nl_accum
// Self-checking bench for pool_nl_accum. The bench plays the role of the
// 5-stage adder tree (a simple value pipeline that moves on adder_enable)
// and of the upstream producer and downstream consumer. Fixed vectors cover
// the documented examples; hand sequences cover latency, enable gaps, stall,
// overflow, reset and clear; random rounds are checked against a reference
// model that works directly on the list of issued samples.

module tb_pool_nl_accum;

   localparam int W = 16;

   typedef struct {
      int n_pass;
      int pool;
      int bias_v;
      int n_in;
      int xs[4];
      int n_out;
      int lin[4];
      int relu[4];
   } vec_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                clear = 1'b0;
   logic                adder_enable = 1'b0;
   logic                sample_valid = 1'b0;
   logic signed [W-1:0] tree_sum;
   logic signed [W-1:0] bias = '0;
   logic [3:0]          cfg_n_pass = '0;
   logic [1:0]          cfg_pool = '0;
   logic signed [W-1:0] out_data;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic                stall;
   logic                err_overflow;

   logic signed [W-1:0] mac_x = '0;
   logic signed [W-1:0] tpipe [5];

   int errors = 0;
   int checks = 0;
   int got[$];
   int exp_q[$];
   int issued[$];
   vec_t vecs[8];

   pool_nl_accum dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .adder_enable (adder_enable),
      .sample_valid (sample_valid),
      .tree_sum     (tree_sum),
      .bias         (bias),
      .cfg_n_pass   (cfg_n_pass),
      .cfg_pool     (cfg_pool),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .stall        (stall),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   // Stand-in for the adder tree: a value launched on an enabled edge emerges
   // at the tree output after four more enabled edges.
   initial begin
      for (int i = 0; i < 5; i++) tpipe[i] = '0;
   end

   always @(posedge clk) begin
      if (adder_enable) begin
         for (int i = 4; i > 0; i--) tpipe[i] <= tpipe[i-1];
         tpipe[0] <= mac_x;
      end
   end

   assign tree_sum = tpipe[4];

   // Record every value the consumer accepts.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) got.push_back(int'(out_data));
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkQueue(input string tag);
      checkOutput({tag, " count"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         checkOutput($sformatf("%s out[%0d]", tag, i), got[i], exp_q[i]);
   endtask

   // Drive one cycle of inputs shortly after a rising edge. With honor set the
   // producer withholds the sample while stall is high. took reports whether
   // a real sample entered the tree this cycle.
   task automatic applyStimulus(input logic v, input int x, input logic en,
                                input logic clr, input logic honor, output logic took);
      @(posedge clk);
      #1;
      clear        = clr;
      adder_enable = en;
      sample_valid = v && !(honor && stall);
      mac_x        = W'(x);
      took         = sample_valid && en && !clr;
   endtask

   task automatic idle(input int n, input logic en);
      logic t;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, en, 1'b0, 1'b0, t);
   endtask

   task automatic doClear(input int n, input int p);
      logic t;
      cfg_n_pass = 4'(n);
      cfg_pool   = 2'(p);
      applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0, t);
   endtask

   task automatic issue(input int x);
      logic t;
      applyStimulus(1'b1, x, 1'b1, 1'b0, 1'b0, t);
   endtask

   // Reference: group issued samples into output values, saturate, apply the
   // nonlinearity, then take the maximum of each complete pool window.
   task automatic buildExpected(input int n, input int p, input int b);
      int neff, k, s, pm;
      int vals[$];
      neff = (n == 0) ? 1 : n;
      k    = (p == 0) ? 1 : ((p == 1) ? 2 : 4);
      for (int g = 0; g + neff <= issued.size(); g += neff) begin
         s = b;
         for (int j = 0; j < neff; j++) s += issued[g+j];
         if (s > 32767) s = 32767;
         if (s < -32768) s = -32768;
`ifdef POOL_NL_RELU_EN
         if (s < 0) s = 0;
`endif
         vals.push_back(s);
      end
      for (int g = 0; g + k <= vals.size(); g += k) begin
         pm = vals[g];
         for (int j = 1; j < k; j++) if (vals[g+j] > pm) pm = vals[g+j];
         exp_q.push_back(pm);
      end
   endtask

   function automatic vec_t mk(int n, int p, int b, int ni, int x0, int x1, int x2, int x3,
                               int no, int l0, int l1, int l2, int r0, int r1, int r2);
      vec_t v;
      v.n_pass = n; v.pool = p; v.bias_v = b; v.n_in = ni; v.n_out = no;
      v.xs[0] = x0; v.xs[1] = x1; v.xs[2] = x2; v.xs[3] = x3;
      v.lin[0] = l0; v.lin[1] = l1; v.lin[2] = l2; v.lin[3] = 0;
      v.relu[0] = r0; v.relu[1] = r1; v.relu[2] = r2; v.relu[3] = 0;
      return v;
   endfunction

   initial begin
      logic t;
      int first_cycle;
      int n_issued;
      int rn, rp, rb;

      vecs[0] = mk(1, 0, 0,   3, 5, -3, 0, 0,                     3, 5, -3, 0,     5, 0, 0);
      vecs[1] = mk(4, 0, 100, 4, 1, 2, 3, 4,                      1, 110, 0, 0,    110, 0, 0);
      vecs[2] = mk(4, 0, 0,   4, 30000, 30000, 30000, 30000,      1, 32767, 0, 0,  32767, 0, 0);
      vecs[3] = mk(4, 0, 0,   4, -30000, -30000, -30000, -30000,  1, -32768, 0, 0, 0, 0, 0);
      vecs[4] = mk(1, 1, 0,   4, 7, 12, -4, 3,                    2, 12, 3, 0,     12, 3, 0);
      vecs[5] = mk(1, 3, 0,   4, 1, 9, 2, 5,                      1, 9, 0, 0,      9, 0, 0);
      vecs[6] = mk(0, 2, 0,   4, -5, -2, -9, -7,                  1, -2, 0, 0,     0, 0, 0);
      vecs[7] = mk(2, 1, -10, 4, 3, 4, 100, -50,                  1, 40, 0, 0,     40, 0, 0);

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset out_valid", int'(out_valid), 0);
      checkOutput("reset out_data", int'(out_data), 0);
      checkOutput("reset stall", int'(stall), 0);
      checkOutput("reset err_overflow", int'(err_overflow), 0);
      rst = 1'b0;

      // Documented examples.
      for (int i = 0; i < 8; i++) begin
         got.delete();
         exp_q.delete();
         out_ready = 1'b1;
         bias = W'(vecs[i].bias_v);
         doClear(vecs[i].n_pass, vecs[i].pool);
         for (int j = 0; j < vecs[i].n_in; j++) issue(vecs[i].xs[j]);
         idle(12, 1'b1);
         for (int j = 0; j < vecs[i].n_out; j++) begin
`ifdef POOL_NL_RELU_EN
            exp_q.push_back(vecs[i].relu[j]);
`else
            exp_q.push_back(vecs[i].lin[j]);
`endif
         end
         checkQueue($sformatf("vec%0d", i));
      end

      // Latency: counting the cycle that carries the sample as cycle 1,
      // out_valid is first seen high in cycle 7.
      bias = '0;
      got.delete();
      out_ready = 1'b1;
      doClear(1, 0);
      issue(77);
      first_cycle = 0;
      for (int c = 2; c <= 20; c++) begin
         applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, t);
         @(negedge clk);
         if (out_valid && first_cycle == 0) first_cycle = c;
      end
      checkOutput("latency cycle", first_cycle, 7);
      checkOutput("latency data count", got.size(), 1);
      if (got.size() > 0) checkOutput("latency data", got[0], 77);

      // Enable gaps: the valid bit waits with the tree; one output, no repeats.
      got.delete();
      doClear(1, 0);
      issue(42);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, t);
         applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, t);
      end
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, t);
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, t);
      @(negedge clk);
      checkOutput("gap early outputs", got.size(), 0);
      idle(10, 1'b0);
      checkOutput("gap output count", got.size(), 1);
      if (got.size() > 0) checkOutput("gap output value", got[0], 42);

      // Stall honoured with the consumer blocked: exactly 8 samples get in.
      got.delete();
      out_ready = 1'b0;
      doClear(1, 0);
      n_issued = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, n_issued + 1, 1'b1, 1'b0, 1'b1, t);
         if (t) n_issued++;
      end
      #1;
      checkOutput("stall issued", n_issued, 8);
      checkOutput("stall level", int'(stall), 1);
      checkOutput("stall no overflow", int'(err_overflow), 0);
      out_ready = 1'b1;
      idle(12, 1'b1);
      exp_q.delete();
      for (int i = 1; i <= 8; i++) exp_q.push_back(i);
      checkQueue("stall drain");
      checkOutput("stall after drain", int'(stall), 0);

      // Stall ignored for one extra sample: the ninth result is dropped.
      got.delete();
      out_ready = 1'b0;
      doClear(1, 0);
      for (int i = 0; i < 9; i++) issue(10 + i);
      idle(10, 1'b1);
      checkOutput("overflow flag", int'(err_overflow), 1);
      out_ready = 1'b1;
      idle(12, 1'b1);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(10 + i);
      checkQueue("overflow drain");
      checkOutput("overflow sticky", int'(err_overflow), 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async rst err_overflow", int'(err_overflow), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset mid-accumulation with results waiting in the FIFO.
      got.delete();
      out_ready = 1'b0;
      doClear(4, 0);
      for (int i = 0; i < 4; i++) issue(1);
      issue(50);
      issue(50);
      idle(8, 1'b1);
      checkOutput("pre-rst out_valid", int'(out_valid), 1);
      checkOutput("pre-rst out_data", int'(out_data), 4);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async rst out_valid", int'(out_valid), 0);
      checkOutput("async rst out_data", int'(out_data), 0);
      checkOutput("async rst stall", int'(stall), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      issue(1);
      issue(1);
      idle(10, 1'b1);
      exp_q.delete();
      exp_q.push_back(1);
      exp_q.push_back(1);
      checkQueue("post-rst defaults");
      got.delete();
      doClear(4, 0);
      for (int i = 0; i < 4; i++) issue(1);
      idle(10, 1'b1);
      exp_q.delete();
      exp_q.push_back(4);
      checkQueue("post-rst n_pass4");

      // clear on the edge a sample leaves the tree, and with a new sample.
      got.delete();
      doClear(1, 0);
      issue(1000);
      idle(4, 1'b1);
      cfg_n_pass = 4'd2;
      cfg_pool   = 2'd0;
      applyStimulus(1'b1, 500, 1'b1, 1'b1, 1'b0, t);
      issue(3);
      issue(4);
      idle(12, 1'b1);
      exp_q.delete();
      exp_q.push_back(7);
      checkQueue("clear priority");

      // Random rounds against the reference model.
      for (int r = 0; r < 6; r++) begin
         rn = $urandom_range(0, 4);
         rp = $urandom_range(0, 3);
         rb = int'($urandom_range(0, 2000)) - 1000;
         bias = W'(rb);
         got.delete();
         exp_q.delete();
         issued.delete();
         out_ready = 1'b1;
         doClear(rn, rp);
         for (int c = 0; c < 80; c++) begin
            int x;
            x = int'($urandom_range(0, 60000)) - 30000;
            out_ready = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 1)), x, ($urandom_range(0, 3) != 0),
                          1'b0, 1'b1, t);
            if (t) issued.push_back(x);
         end
         out_ready = 1'b1;
         idle(30, 1'b1);
         buildExpected(rn, rp, rb);
         checkQueue($sformatf("random%0d n=%0d p=%0d", r, rn, rp));
         checkOutput($sformatf("random%0d err_overflow", r), int'(err_overflow), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
